muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit for the RV32M extension. It sits in the execute stage beside the single-cycle integer ALU and takes the same operand pair and `funct3` encoding. It accepts one operation through a start/busy/done handshake, computes it over `Width` iterations, and returns a registered result. The pipeline stalls on `busy` and writes back on `done`.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle, with a final sign-fix / special-case cycle.
module muldiv_unit #(
    parameter  int Width             = 32,
    localparam int ISA__FUNCT3_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         kill,
    input  logic [Width-1:0]             a,
    input  logic [Width-1:0]             b,
    input  logic [ISA__FUNCT3_WIDTH-1:0] op,
    output logic                         busy,
    output logic                         done,
    output logic [Width-1:0]             c
);
    localparam int CntW = $clog2(Width);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                         state_reg;
    logic [ISA__FUNCT3_WIDTH-1:0]   op_reg;
    logic [Width:0]                 a_mag_reg, b_mag_reg;
    logic                           a_neg_reg, b_neg_reg;
    logic [Width-1:0]               a_orig_reg;
    logic [2*Width:0]               acc_reg;
    logic [CntW-1:0]                count_reg;
    logic [Width-1:0]               c_reg;
    logic                           done_reg, busy_reg;

    // Operand conditioning at acceptance: sign bits and Width+1-bit magnitudes.
    logic           sign_a, sign_b;
    logic [Width:0] a_mag_in, b_mag_in;

    assign sign_a   = a[Width-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign sign_b   = b[Width-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign a_mag_in = sign_a ? ({1'b0, ~a} + {{Width{1'b0}}, 1'b1}) : {1'b0, a};
    assign b_mag_in = sign_b ? ({1'b0, ~b} + {{Width{1'b0}}, 1'b1}) : {1'b0, b};

    // Multiply step: acc = {partial product (Width+1), remaining multiplier (Width)}.
    logic [Width:0]   mul_sum;
    logic [2*Width:0] mul_next;

    assign mul_sum  = acc_reg[2*Width:Width] + (acc_reg[0] ? a_mag_reg : '0);
    assign mul_next = {1'b0, mul_sum, acc_reg[Width-1:1]};

    // Divide step: acc = {remainder (Width+1), dividend bits / quotient bits (Width)}.
    logic [Width:0]   div_rem_sh, div_rem_new;
    logic [Width+1:0] div_trial;
    logic             q_bit;
    logic [2*Width:0] div_next;

    assign div_rem_sh  = {acc_reg[2*Width-1:Width], acc_reg[Width-1]};
    assign div_trial   = {1'b0, div_rem_sh} - {1'b0, b_mag_reg};
    assign q_bit       = ~div_trial[Width+1];
    assign div_rem_new = q_bit ? div_trial[Width:0] : div_rem_sh;
    assign div_next    = {div_rem_new, acc_reg[Width-2:0], q_bit};

    // Sign correction and result selection for the FIX cycle.
    logic [2*Width-1:0] prod, prod_fix;
    logic [Width-1:0]   quot_fix, rem_fix, result;
    logic               div_zero, overflow;

    assign prod     = acc_reg[2*Width-1:0];
    assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -prod : prod;
    assign quot_fix = (a_neg_reg ^ b_neg_reg) ? -acc_reg[Width-1:0] : acc_reg[Width-1:0];
    assign rem_fix  = a_neg_reg ? -acc_reg[2*Width-1:Width] : acc_reg[2*Width-1:Width];
    assign div_zero = (b_mag_reg == '0);
    assign overflow = (a_orig_reg == {1'b1, {(Width-1){1'b0}}}) && b_neg_reg
                      && (b_mag_reg == {{Width{1'b0}}, 1'b1});

    always_comb begin
        result = '0;
        case (op_reg)
            OP_MUL:                       result = prod_fix[Width-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*Width-1:Width];
            OP_DIV, OP_DIVU: begin
                if (div_zero)      result = '1;
                else if (overflow) result = {1'b1, {(Width-1){1'b0}}};
                else               result = quot_fix;
            end
            default: begin
                if (div_zero)      result = a_orig_reg;
                else if (overflow) result = '0;
                else               result = rem_fix;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            a_orig_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            c_reg      <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !kill) begin
                        op_reg     <= op;
                        a_mag_reg  <= a_mag_in;
                        b_mag_reg  <= b_mag_in;
                        a_neg_reg  <= sign_a;
                        b_neg_reg  <= sign_b;
                        a_orig_reg <= a;
                        acc_reg    <= op[2] ? {{(Width+1){1'b0}}, a_mag_in[Width-1:0]}
                                            : {{(Width+1){1'b0}}, b_mag_in[Width-1:0]};
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= op_reg[2] ? div_next : mul_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CntW'(Width - 1))
                            state_reg <= FIX;
                    end
                end
                FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (!kill) begin
                        c_reg    <= result;
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign c    = c_reg;

endmodule
